// File: rtl/chip8_pkg.sv
// Shared keypad types: key count, scan FSM states and the event record
// exchanged between the scanner and its event FIFO.
package chip8_pkg;

  localparam int KEY_COUNT = 16;

  typedef enum logic {
    SCAN_SETTLE = 1'b0,
    SCAN_EVAL   = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic       press;
    logic [3:0] code;
  } key_event_t;

endpackage

// File: rtl/key_event_fifo.sv
// Four-entry in-order key event FIFO with valid/ready pop; a push while full
// is accepted only when a pop frees a slot on the same edge.
module key_event_fifo
  import chip8_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [4:0] push_data,
  input  logic       pop_ready,
  output logic [4:0] pop_data,
  output logic       full,
  output logic       empty
);

  logic [4:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       do_push;
  logic       do_pop;

  assign empty    = (count == 3'd0);
  assign full     = (count == 3'd4);
  assign do_pop   = pop_ready && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with per-key debounce and a small press/release
// event FIFO. Each row: SETTLE_CYCLES of settling, then 4 EVAL cycles.
//
// state       | meaning
// SCAN_SETTLE | current row driven low, waiting for columns to settle
// SCAN_EVAL   | one column of the latched sample debounced per cycle
module keypad_scanner
  import chip8_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 256,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic [15:0] keypad_matrix,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [3:0]  ev_code,
  output logic        ev_press,
  output logic        ev_overflow
);

  localparam logic [11:0] SETTLE_LAST = 12'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  DEB_LAST    = 4'(DEBOUNCE_SCANS - 1);

  scan_state_t state;
  logic [1:0]  row;
  logic [1:0]  row_next;
  logic [11:0] settle_cnt;
  logic [1:0]  col_idx;
  logic [3:0]  col_s1;
  logic [3:0]  col_s2;
  logic [3:0]  col_sample;
  logic [3:0]  deb_cnt [KEY_COUNT];

  logic [3:0]  eval_key;
  logic        eval_sample;
  logic        eval_stable;
  logic        eval_flip;
  logic        push;
  key_event_t  push_ev;
  key_event_t  head_ev;
  logic        fifo_full;
  logic        fifo_empty;

  always_comb begin
    row_next    = row + 2'd1;
    eval_key    = {row, col_idx};
    eval_sample = ~col_sample[col_idx];
    eval_stable = keypad_matrix[eval_key];
    eval_flip   = (state == SCAN_EVAL) && (eval_sample != eval_stable) &&
                  (deb_cnt[eval_key] == DEB_LAST);
    // Reset suppresses the push so an aborted EVAL leaves no stray event.
    push          = eval_flip && !reset;
    push_ev.press = eval_sample;
    push_ev.code  = eval_key;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SCAN_SETTLE;
      row           <= 2'd0;
      row_n         <= 4'b1110;
      settle_cnt    <= '0;
      col_idx       <= 2'd0;
      col_s1        <= 4'hF;
      col_s2        <= 4'hF;
      col_sample    <= 4'hF;
      keypad_matrix <= '0;
      ev_overflow   <= 1'b0;
      for (int k = 0; k < KEY_COUNT; k++) deb_cnt[k] <= '0;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
      case (state)
        SCAN_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            col_sample <= col_s2;
            settle_cnt <= '0;
            col_idx    <= 2'd0;
            state      <= SCAN_EVAL;
          end else begin
            settle_cnt <= settle_cnt + 12'd1;
          end
        end
        SCAN_EVAL: begin
          if (eval_sample == eval_stable) begin
            deb_cnt[eval_key] <= '0;
          end else if (eval_flip) begin
            keypad_matrix[eval_key] <= eval_sample;
            deb_cnt[eval_key]       <= '0;
          end else begin
            deb_cnt[eval_key] <= deb_cnt[eval_key] + 4'd1;
          end
          if (col_idx == 2'd3) begin
            row   <= row_next;
            row_n <= ~(4'b0001 << row_next);
            state <= SCAN_SETTLE;
          end else begin
            col_idx <= col_idx + 2'd1;
          end
        end
        default: state <= SCAN_SETTLE;
      endcase
      // Full FIFO implies non-empty, so a pop happens exactly when ev_ready.
      if (push && fifo_full && !ev_ready) ev_overflow <= 1'b1;
    end
  end

  key_event_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_ev),
    .pop_ready (ev_ready),
    .pop_data  (head_ev),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = head_ev.code;
  assign ev_press = head_ev.press;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: behavioural keypad matrix, table of hold patterns,
// hand sequences for debounce timing, overflow and reset abort.
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int SCAN   = 4 * (SETTLE + 4);

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keypad_matrix;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_code;
  logic        ev_press;
  logic        ev_overflow;

  logic [15:0] held;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        exp_ovf;

  typedef struct {
    logic [3:0] code;
    logic       press;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    logic [15:0] hold;
    int          scans;
    logic [15:0] exp_matrix;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  keypad_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .row_n         (row_n),
    .col_n         (col_n),
    .keypad_matrix (keypad_matrix),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_code       (ev_code),
    .ev_press      (ev_press),
    .ev_overflow   (ev_overflow)
  );

  // Physical keypad: a held key shorts its row strobe onto its column.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && held[r*4+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got code %0h press %0b, none expected", ev_code, ev_press);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (e.code !== ev_code || e.press !== ev_press) begin
          n_fail++;
          $display("FAIL event_order: got code %0h press %0b, expected code %0h press %0b",
                   ev_code, ev_press, e.code, e.press);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [3:0] code, input logic press);
    ev_t e;
    if (!ev_ready && sb.size() >= 4) begin
      exp_ovf = 1'b1;
    end else begin
      e.code  = code;
      e.press = press;
      sb.push_back(e);
    end
  endtask

  // Expected events for a hold change confined to one row: ascending key order.
  task automatic apply_hold(input logic [15:0] nh);
    for (int k = 0; k < 16; k++)
      if (nh[k] != held[k]) expect_ev(4'(k), nh[k]);
    held = nh;
  endtask

  task automatic wait_row(input int r, output int cycles);
    logic [3:0] target;
    logic [3:0] prev;
    target = ~(4'b0001 << r);
    prev   = row_n;
    cycles = 0;
    while (1) begin
      @(posedge clk); #1;
      cycles++;
      if (row_n == target && prev != target) break;
      prev = row_n;
      if (cycles > 4 * SCAN) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wait_row_timeout: row %0d not reached in %0d cycles", r, cycles);
        break;
      end
    end
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN) @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    vecs[0] = '{16'h0020, 5, 16'h0020};
    vecs[1] = '{16'h0000, 5, 16'h0000};
    vecs[2] = '{16'h00F0, 5, 16'h00F0};
    vecs[3] = '{16'h0000, 5, 16'h0000};
    vecs[4] = '{16'h8000, 5, 16'h8000};
    vecs[5] = '{16'h9000, 5, 16'h9000};
    vecs[6] = '{16'h0000, 5, 16'h0000};

    reset    = 1'b1;
    held     = 16'h0000;
    ev_ready = 1'b1;
    exp_ovf  = 1'b0;
    @(posedge clk); #1;
    check("reset_row_n", 32'(row_n), 32'hE);
    check("reset_matrix", 32'(keypad_matrix), 32'h0);
    check("reset_ev_valid", 32'(ev_valid), 32'h0);
    check("reset_overflow", 32'(ev_overflow), 32'h0);
    reset = 1'b0;

    wait_row(0, cyc);
    wait_row(0, cyc);
    check("scan_period", 32'(cyc), 32'(SCAN));

    for (int i = 0; i < 7; i++) begin
      apply_hold(vecs[i].hold);
      wait_scans(vecs[i].scans);
      check($sformatf("vec%0d_matrix", i), 32'(keypad_matrix), 32'(vecs[i].exp_matrix));
      check($sformatf("vec%0d_drained", i), 32'(sb.size()), 32'h0);
    end

    // Three samples of a press are not enough to flip.
    wait_row(2, cyc);
    held = 16'h0020;
    repeat (3) wait_row(2, cyc);
    held = 16'h0000;
    wait_scans(3);
    check("glitch_matrix", 32'(keypad_matrix), 32'h0);
    check("glitch_no_event", 32'(ev_valid), 32'h0);

    // Exactly the fourth sample flips, both directions.
    wait_row(2, cyc);
    apply_hold(16'h0020);
    repeat (3) wait_row(2, cyc);
    check("press_3_samples", 32'(keypad_matrix), 32'h0);
    wait_row(2, cyc);
    check("press_4_samples", 32'(keypad_matrix), 32'h0020);
    apply_hold(16'h0000);
    repeat (3) wait_row(2, cyc);
    check("release_3_samples", 32'(keypad_matrix), 32'h0020);
    wait_row(2, cyc);
    check("release_4_samples", 32'(keypad_matrix), 32'h0);
    wait_scans(1);
    check("timing_drained", 32'(sb.size()), 32'h0);

    // Overflow: consumer stalled, five presses into a four-deep FIFO.
    @(posedge clk); #1;
    ev_ready = 1'b0;
    apply_hold(16'h000F);
    wait_scans(5);
    check("ovf_fill_matrix", 32'(keypad_matrix), 32'h000F);
    check("ovf_head_code", 32'(ev_code), 32'h0);
    check("ovf_no_overflow_yet", 32'(ev_overflow), 32'h0);
    apply_hold(16'h001F);
    wait_scans(5);
    check("ovf_matrix", 32'(keypad_matrix), 32'h001F);
    check("ovf_flag", 32'(ev_overflow), 32'(exp_ovf));
    check("ovf_head_stable_code", 32'(ev_code), 32'h0);
    check("ovf_head_stable_press", 32'(ev_press), 32'h1);
    ev_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("ovf_drained", 32'(sb.size()), 32'h0);
    check("ovf_empty", 32'(ev_valid), 32'h0);
    apply_hold(16'h000F);
    wait_scans(5);
    apply_hold(16'h0000);
    wait_scans(5);
    check("ovf_sticky", 32'(ev_overflow), 32'h1);
    check("ovf_release_drained", 32'(sb.size()), 32'h0);

    // Reset in the middle of row 2's EVAL while key A is held.
    apply_hold(16'h0400);
    wait_scans(5);
    check("keyA_matrix", 32'(keypad_matrix), 32'h0400);
    wait_row(2, cyc);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_matrix", 32'(keypad_matrix), 32'h0);
    check("midreset_row_n", 32'(row_n), 32'hE);
    check("midreset_ev_valid", 32'(ev_valid), 32'h0);
    check("midreset_overflow", 32'(ev_overflow), 32'h0);
    expect_ev(4'hA, 1'b1);
    repeat (3) wait_row(3, cyc);
    check("midreset_3_samples", 32'(keypad_matrix), 32'h0);
    wait_row(3, cyc);
    check("midreset_4_samples", 32'(keypad_matrix), 32'h0400);
    repeat (4) @(posedge clk); #1;
    check("final_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
